// File: rtl/seq_modulo_pkg.sv
// Shared constants for the iterative divide/modulo peripheral.
//   ADDR_*  : register select codes seen on the ADDR bus
//   ST_*    : bit positions inside the STATUS word
package seq_modulo_pkg;

  localparam logic [1:0] ADDR_X      = 2'd0;
  localparam logic [1:0] ADDR_Y      = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_DZ   = 2;

endpackage

// File: rtl/restoring_div_core.sv
// Restoring divider, one quotient bit per clock.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset (abandons a run)
//   start      : begin a run when idle; latches dividend and divisor
//   dividend   : WIDTH-bit numerator
//   divisor    : WIDTH-bit denominator (caller guarantees non-zero)
//   busy       : high from the start edge until the final step edge
//   done       : high in the cycle whose closing edge performs the final step
//   quotient   : value the quotient takes at that edge (valid with done)
//   remainder  : value the remainder takes at that edge (valid with done)
module restoring_div_core
  import seq_modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_dvd_nx;
  logic             w_load;

  // The partial remainder is kept below the divisor, so the shifted value
  // fits in WIDTH+1 bits and bit WIDTH of the difference is a clean borrow.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_dvs};
    w_qbit   = ~w_diff[WIDTH];
    w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    // Quotient bits shift into the vacated low end of the dividend.
    w_dvd_nx = {r_dvd[WIDTH-2:0], w_qbit};
  end

  assign busy      = (r_cnt != '0);
  assign done      = (r_cnt == CNT_W'(1));
  assign quotient  = w_dvd_nx;
  assign remainder = w_rem_nx;
  assign w_load    = start && !busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_dvd <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (busy) begin
      r_dvd <= w_dvd_nx;
      r_rem <= w_rem_nx;
    end
  end

endmodule

// File: rtl/seq_modulo_unit.sv
// Memory-mapped divide/modulo peripheral.
// Software writes X, then Y (which starts a run), polls STATUS, then reads
// RESULT = {quotient, remainder}.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   D        : WIDTH-bit write data
//   ADDR     : 0=X, 1=Y, 2=RESULT, 3=STATUS
//   W, R     : write / read strobes, qualified by E
//   E        : bus enable
//   OUT      : registered read data (holds when not reading)
//   BUSY     : divider iterating (same as STATUS bit0)
module seq_modulo_unit
  import seq_modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   D,
  input  logic [1:0]         ADDR,
  input  logic               W,
  input  logic               R,
  input  logic               E,
  output logic [2*WIDTH-1:0] OUT,
  output logic               BUSY
);

  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;
  logic               r_dz;
  logic [2*WIDTH-1:0] r_out;

  logic               w_busy;
  logic               w_core_done;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic               w_wr;
  logic               w_rd;
  logic               w_start;
  logic               w_start_core;
  logic               w_start_dz;
  logic [2*WIDTH-1:0] w_status;
  logic [2*WIDTH-1:0] w_rd_data;

  // All writes are dropped while a run is in flight.
  assign w_wr         = E && W && !w_busy;
  assign w_rd         = E && R;
  assign w_start      = w_wr && (ADDR == ADDR_Y);
  assign w_start_dz   = w_start && (D == '0);
  assign w_start_core = w_start && (D != '0);

  restoring_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .CLK       (CLK),
    .RST       (RST),
    .start     (w_start_core),
    .dividend  (r_x),
    .divisor   (D),
    .busy      (w_busy),
    .done      (w_core_done),
    .quotient  (w_q),
    .remainder (w_r)
  );

  always_comb begin
    w_status          = '0;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_DONE] = r_done;
    w_status[ST_DZ]   = r_dz;
  end

  always_comb begin
    case (ADDR)
      ADDR_X:      w_rd_data = {{WIDTH{1'b0}}, r_x};
      ADDR_Y:      w_rd_data = {{WIDTH{1'b0}}, r_y};
      ADDR_RESULT: w_rd_data = r_result;
      default:     w_rd_data = w_status;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_out    <= '0;
    end else begin
      if (w_wr && (ADDR == ADDR_X)) begin
        r_x <= D;
      end
      if (w_start) begin
        r_y <= D;
      end
      // A start cannot coincide with core completion: completion implies busy.
      if (w_start) begin
        r_done <= w_start_dz;
        r_dz   <= w_start_dz;
        if (w_start_dz) begin
          // Divide-by-zero bypass: all-ones quotient, dividend as remainder.
          r_result <= {{WIDTH{1'b1}}, r_x};
        end
      end else if (w_core_done) begin
        r_result <= {w_q, w_r};
        r_done   <= 1'b1;
      end
      // The mux sees pre-edge state, so a same-edge write is not reflected.
      if (w_rd) begin
        r_out <= w_rd_data;
      end
    end
  end

  assign OUT  = r_out;
  assign BUSY = w_busy;

endmodule

// File: tb/tb_seq_modulo_unit.sv
module tb_seq_modulo_unit;

  localparam logic [1:0] A_X = 2'd0;
  localparam logic [1:0] A_Y = 2'd1;
  localparam logic [1:0] A_RES = 2'd2;
  localparam logic [1:0] A_ST = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] D;
  logic [1:0]  ADDR;
  logic        W, R, E;
  logic [31:0] OUT;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] res;
    logic [31:0] st;
  } vec_t;

  vec_t        vt[7];
  logic [31:0] q, st, prev_res, exp_res;
  logic [15:0] rx, ry;
  int          n;

  seq_modulo_unit #(.WIDTH(16)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .D    (D),
    .ADDR (ADDR),
    .W    (W),
    .R    (R),
    .E    (E),
    .OUT  (OUT),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: plain integer division with the zero-divisor rule.
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] qq, rr;
    if (y == 16'd0) return {16'hFFFF, x};
    qq = x / y;
    rr = x % y;
    return {qq, rr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    E = 1'b0; W = 1'b0; R = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    E = 1'b1; W = 1'b1; R = 1'b0; ADDR = a; D = d;
    tick();
    E = 1'b0; W = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] data);
    E = 1'b1; R = 1'b1; W = 1'b0; ADDR = a;
    tick();
    data = OUT;
    E = 1'b0; R = 1'b0;
  endtask

  task automatic poll(output logic [31:0] s);
    int k;
    k = 0;
    s = '0;
    while (!s[1] && k < 40) begin
      rd(A_ST, s);
      k++;
    end
    check("poll_done", {31'b0, s[1]}, 32'd1);
  endtask

  initial begin
    vt[0] = '{16'd5,     16'd4,     32'h00010001, 32'h2};
    vt[1] = '{16'd445,   16'd100,   32'h0004002D, 32'h2};
    vt[2] = '{16'd65535, 16'd65535, 32'h00010000, 32'h2};
    vt[3] = '{16'd3,     16'd65535, 32'h00000003, 32'h2};
    vt[4] = '{16'd7,     16'd0,     32'hFFFF0007, 32'h6};
    vt[5] = '{16'd20,    16'd6,     32'h00030002, 32'h2};
    vt[6] = '{16'd0,     16'd5,     32'h00000000, 32'h2};

    RST = 1'b1; E = 1'b0; W = 1'b0; R = 1'b0; ADDR = 2'd0; D = '0;
    repeat (2) tick();
    RST = 1'b0;
    check("reset_out", OUT, 32'h0);
    check("reset_busy", {31'b0, BUSY}, 32'h0);
    rd(A_X, q);   check("reset_x", q, 32'h0);
    rd(A_Y, q);   check("reset_y", q, 32'h0);
    rd(A_RES, q); check("reset_result", q, 32'h0);
    rd(A_ST, q);  check("reset_status", q, 32'h0);

    // BUSY width after the Y-write edge
    wr(A_X, 16'd5);
    wr(A_Y, 16'd4);
    n = 0;
    while (BUSY && n < 100) begin
      n++;
      idle();
    end
    check("busy_cycles", n, 32'd16);
    poll(st);
    check("status_5_4", st, 32'h2);
    rd(A_RES, q); check("result_5_4", q, 32'h00010001);

    // STATUS read at the completion edge still shows the run in progress
    wr(A_Y, 16'd4);
    repeat (15) idle();
    rd(A_ST, q); check("status_completion_edge", q, 32'h1);
    rd(A_ST, q); check("status_first_done", q, 32'h2);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      wr(A_X, vt[i].x);
      wr(A_Y, vt[i].y);
      if (vt[i].y == 16'd0) begin
        check("dz_busy_low", {31'b0, BUSY}, 32'h0);
        rd(A_ST, st);
      end else begin
        poll(st);
      end
      check($sformatf("table%0d_status", i), st, vt[i].st);
      rd(A_RES, q);
      check($sformatf("table%0d_result", i), q, vt[i].res);
    end

    // Writes during a run are ignored
    wr(A_X, 16'd100);
    wr(A_Y, 16'd7);
    wr(A_X, 16'd9);
    wr(A_Y, 16'd3);
    poll(st);
    rd(A_RES, q); check("ignore_result", q, 32'h000E0002);
    rd(A_X, q);   check("ignore_x", q, 32'h00000064);
    rd(A_Y, q);   check("ignore_y", q, 32'h00000007);

    // Same-edge read and write returns the pre-edge value
    E = 1'b1; W = 1'b1; R = 1'b1; ADDR = A_X; D = 16'h1234;
    tick();
    E = 1'b0; W = 1'b0; R = 1'b0;
    check("rw_same_edge_out", OUT, 32'h00000064);
    rd(A_X, q); check("rw_same_edge_x", q, 32'h00001234);

    // Back-to-back: a start one edge early is dropped, the next is taken
    wr(A_X, 16'd50);
    wr(A_Y, 16'd7);
    repeat (15) idle();
    wr(A_Y, 16'd9);
    wr(A_Y, 16'd5);
    check("b2b_busy", {31'b0, BUSY}, 32'h1);
    poll(st);
    rd(A_RES, q); check("b2b_result", q, 32'h000A0000);
    rd(A_Y, q);   check("b2b_y", q, 32'h00000005);

    // Reset in the middle of a run
    wr(A_X, 16'd1000);
    rd(A_X, q); check("pre_rst_x", q, 32'd1000);
    wr(A_Y, 16'd3);
    repeat (4) idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_out", OUT, 32'h0);
    check("midrst_busy", {31'b0, BUSY}, 32'h0);
    rd(A_ST, q);  check("midrst_status", q, 32'h0);
    rd(A_RES, q); check("midrst_result", q, 32'h0);
    rd(A_X, q);   check("midrst_x", q, 32'h0);
    wr(A_X, 16'd20);
    wr(A_Y, 16'd6);
    poll(st);
    rd(A_RES, q); check("post_rst_result", q, 32'h00030002);

    // Bus enable low: strobes are ignored
    rd(A_ST, q); check("e0_pre_status", q, 32'h2);
    E = 1'b0; W = 1'b1; R = 1'b1; ADDR = A_X; D = 16'hBEEF;
    tick();
    W = 1'b0; R = 1'b0;
    check("e0_out_hold", OUT, 32'h2);
    rd(A_X, q); check("e0_x_unchanged", q, 32'd20);

    // Randomized runs against the reference model
    prev_res = 32'h00030002;
    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      if (i % 6 == 0)      ry = 16'd0;
      else if (i % 2 == 1) ry = 16'($urandom_range(1, 20));
      else                 ry = 16'($urandom);
      exp_res = model(rx, ry);
      wr(A_X, rx);
      wr(A_Y, ry);
      if (ry != 16'd0) begin
        rd(A_RES, q);
        check($sformatf("rand%0d_result_while_busy", i), q, prev_res);
        poll(st);
        check($sformatf("rand%0d_status", i), st, 32'h2);
      end else begin
        rd(A_ST, st);
        check($sformatf("rand%0d_status_dz", i), st, 32'h6);
      end
      rd(A_RES, q);
      check($sformatf("rand%0d_result_%0d_%0d", i, rx, ry), q, exp_res);
      prev_res = exp_res;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
